// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with runtime almost-full/almost-empty thresholds,
// optional first-word-fall-through, non-power-of-two depth and flush.
module fifo_sync_prog #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter bit FWFT       = 1'b0,
   localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   input  logic [CW-1:0]         af_level,
   input  logic [CW-1:0]         ae_level,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [CW-1:0]         count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

   logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [FIFO_WIDTH-1:0] dout_q, dout_d;
   logic                  dvalid_q, dvalid_d;
   logic                  wr_ack_q, wr_ack_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;

   logic                  wr_ok;
   logic                  rd_ok;
   logic [FIFO_WIDTH-1:0] head;

   assign full        = (count_q == DEPTH_C);
   assign empty       = (count_q == '0);
   assign almostfull  = (count_q >= af_level);
   assign almostempty = (count_q <= ae_level);
   assign count       = count_q;

   assign wr_ok = wr_en && !full && !flush;
   assign rd_ok = rd_en && !empty && !flush;
   assign head  = mem_q[rd_ptr_q];

   assign wr_ack    = wr_ack_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

   // FWFT shows the head word live; when empty it keeps the last word seen
   assign data_out   = (FWFT && !empty) ? head : dout_q;
   assign data_valid = FWFT ? !empty : dvalid_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      dvalid_d = 1'b0;
      wr_ack_d = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ack_d = wr_ok;
         ovf_d    = wr_en && full;
         udf_d    = rd_en && empty;
         dvalid_d = rd_ok;

         if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
         end

         if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
            dout_d   = head;
         end

         unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         wr_ack_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         wr_ack_q <= wr_ack_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is deliberately left uncleared by reset and flush
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench: depth-8 standard, depth-6 standard and depth-8 FWFT
// instances driven from one linear sequence.
module tb_fifo_sync_prog;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // instance A: depth 8, standard read
   logic        a_flush = 0, a_wr = 0, a_rd = 0;
   logic [15:0] a_din = '0, a_dout;
   logic [3:0]  a_af = 4'd6, a_ae = 4'd2, a_cnt;
   logic        a_dv, a_ack, a_ovf, a_udf, a_full, a_empty, a_afull, a_aempty;

   // instance B: depth 6, standard read
   logic        b_flush = 0, b_wr = 0, b_rd = 0;
   logic [15:0] b_din = '0, b_dout;
   logic [2:0]  b_af = 3'd5, b_ae = 3'd1, b_cnt;
   logic        b_dv, b_ack, b_ovf, b_udf, b_full, b_empty, b_afull, b_aempty;

   // instance C: depth 8, FWFT
   logic        c_flush = 0, c_wr = 0, c_rd = 0;
   logic [15:0] c_din = '0, c_dout;
   logic [3:0]  c_af = 4'd6, c_ae = 4'd2, c_cnt;
   logic        c_dv, c_ack, c_ovf, c_udf, c_full, c_empty, c_afull, c_aempty;

   fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b0)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr),
      .data_in(a_din), .rd_en(a_rd), .af_level(a_af), .ae_level(a_ae),
      .data_out(a_dout), .data_valid(a_dv), .wr_ack(a_ack),
      .overflow(a_ovf), .underflow(a_udf), .full(a_full), .empty(a_empty),
      .almostfull(a_afull), .almostempty(a_aempty), .count(a_cnt)
   );

   fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .FWFT(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr),
      .data_in(b_din), .rd_en(b_rd), .af_level(b_af), .ae_level(b_ae),
      .data_out(b_dout), .data_valid(b_dv), .wr_ack(b_ack),
      .overflow(b_ovf), .underflow(b_udf), .full(b_full), .empty(b_empty),
      .almostfull(b_afull), .almostempty(b_aempty), .count(b_cnt)
   );

   fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b1)) u_c (
      .clk(clk), .rst_n(rst_n), .flush(c_flush), .wr_en(c_wr),
      .data_in(c_din), .rd_en(c_rd), .af_level(c_af), .ae_level(c_ae),
      .data_out(c_dout), .data_valid(c_dv), .wr_ack(c_ack),
      .overflow(c_ovf), .underflow(c_udf), .full(c_full), .empty(c_empty),
      .almostfull(c_afull), .almostempty(c_aempty), .count(c_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      // reset values
      chk("rst_cnt", 32'(a_cnt), 0);
      chk("rst_empty", 32'(a_empty), 1);
      chk("rst_full", 32'(a_full), 0);
      chk("rst_dout", 32'(a_dout), 0);
      chk("rst_dv", 32'(a_dv), 0);
      chk("rst_ack", 32'(a_ack), 0);
      chk("rst_ovf", 32'(a_ovf), 0);
      chk("rst_udf", 32'(a_udf), 0);
      chk("rst_c_dv", 32'(c_dv), 0);
      chk("rst_c_dout", 32'(c_dout), 0);
      #10 rst_n = 1'b1;
      step();

      // 1: fill, overflow, drain in order
      a_wr = 1;
      for (int i = 1; i <= 8; i++) begin
         a_din = 16'(i);
         step();
         chk("t1_ack", 32'(a_ack), 1);
         chk("t1_cnt", 32'(a_cnt), 32'(i));
      end
      chk("t1_full", 32'(a_full), 1);
      a_din = 16'hDEAD;
      step();
      chk("t1_ovf", 32'(a_ovf), 1);
      chk("t1_ack9", 32'(a_ack), 0);
      chk("t1_cnt9", 32'(a_cnt), 8);
      a_wr = 0;
      a_rd = 1;
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("t1_dout", 32'(a_dout), 32'(i));
         chk("t1_dv", 32'(a_dv), 1);
         chk("t1_rcnt", 32'(a_cnt), 32'(8 - i));
      end
      a_rd = 0;
      step();
      chk("t1_dv_off", 32'(a_dv), 0);
      chk("t1_empty", 32'(a_empty), 1);

      // 2: underflow, then write+read on empty
      a_rd = 1;
      step();
      chk("t2_udf", 32'(a_udf), 1);
      chk("t2_dv", 32'(a_dv), 0);
      chk("t2_cnt", 32'(a_cnt), 0);
      a_rd = 0;
      step();
      chk("t2_udf_off", 32'(a_udf), 0);
      a_wr = 1; a_rd = 1; a_din = 16'h0055;
      step();
      chk("t2_wr_cnt", 32'(a_cnt), 1);
      chk("t2_wr_udf", 32'(a_udf), 1);
      chk("t2_wr_ack", 32'(a_ack), 1);
      a_rd = 0;

      // 3: simultaneous on full and half full
      for (int i = 1; i <= 7; i++) begin
         a_din = 16'(16'h0100 + i);
         step();
      end
      chk("t3_full", 32'(a_full), 1);
      a_rd = 1; a_din = 16'h0BAD;
      step();
      chk("t3_cnt", 32'(a_cnt), 7);
      chk("t3_ovf", 32'(a_ovf), 1);
      chk("t3_dout", 32'(a_dout), 32'h0055);
      a_wr = 0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("t3_rd", 32'(a_dout), 32'(16'h0100 + i));
      end
      chk("t3_half", 32'(a_cnt), 4);
      a_wr = 1; a_din = 16'h0200;
      step();
      chk("t3_both_cnt", 32'(a_cnt), 4);
      chk("t3_both_ack", 32'(a_ack), 1);
      chk("t3_both_dout", 32'(a_dout), 32'h0104);

      // 5: thresholds (af=6, ae=2)
      a_wr = 0;
      step();
      step();
      chk("t5_cnt2", 32'(a_cnt), 2);
      chk("t5_ae2", 32'(a_aempty), 1);
      chk("t5_af2", 32'(a_afull), 0);
      a_rd = 0; a_wr = 1; a_din = 16'h0301;
      step();
      chk("t5_ae3", 32'(a_aempty), 0);
      for (int i = 2; i <= 4; i++) begin
         a_din = 16'(16'h0300 + i);
         step();
      end
      a_wr = 0;
      chk("t5_cnt6", 32'(a_cnt), 6);
      chk("t5_af6", 32'(a_afull), 1);
      a_af = 4'd7;
      #1;
      chk("t5_af7", 32'(a_afull), 0);
      a_af = 4'd0;
      #1;
      chk("t5_af0", 32'(a_afull), 1);
      a_ae = 4'd8;
      #1;
      chk("t5_ae8", 32'(a_aempty), 1);
      a_af = 4'd6; a_ae = 4'd2;

      // 6: flush beats wr/rd; data_out holds
      a_rd = 1;
      step();
      chk("t6_cnt5", 32'(a_cnt), 5);
      chk("t6_pre_dout", 32'(a_dout), 32'h0107);
      a_flush = 1; a_wr = 1; a_din = 16'h0999;
      step();
      a_flush = 0; a_wr = 0; a_rd = 0;
      chk("t6_fl_cnt", 32'(a_cnt), 0);
      chk("t6_fl_empty", 32'(a_empty), 1);
      chk("t6_fl_ack", 32'(a_ack), 0);
      chk("t6_fl_ovf", 32'(a_ovf), 0);
      chk("t6_fl_udf", 32'(a_udf), 0);
      chk("t6_fl_dv", 32'(a_dv), 0);
      chk("t6_fl_dout", 32'(a_dout), 32'h0107);
      a_wr = 1; a_din = 16'h0400;
      step();
      a_wr = 0; a_rd = 1;
      step();
      a_rd = 0;
      chk("t6_post_dout", 32'(a_dout), 32'h0400);

      // 4: depth-6 wrap with interleaved traffic
      b_wr = 1;
      for (int i = 1; i <= 3; i++) begin
         b_din = 16'(i);
         step();
      end
      b_rd = 1;
      for (int k = 1; k <= 17; k++) begin
         b_din = 16'(k + 3);
         step();
         chk("t4_dout", 32'(b_dout), 32'(k));
         chk("t4_cnt", 32'(b_cnt), 3);
      end
      b_wr = 0;
      for (int k = 18; k <= 20; k++) begin
         step();
         chk("t4_drain", 32'(b_dout), 32'(k));
      end
      b_rd = 0;
      chk("t4_empty", 32'(b_empty), 1);
      b_wr = 1;
      for (int i = 0; i < 6; i++) begin
         b_din = 16'(16'h0A0 + i);
         step();
      end
      b_din = 16'h0FFF;
      chk("t4_full", 32'(b_full), 1);
      chk("t4_cnt6", 32'(b_cnt), 6);
      step();
      b_wr = 0;
      chk("t4_ovf", 32'(b_ovf), 1);
      b_rd = 1;
      step();
      b_rd = 0;
      chk("t4_head", 32'(b_dout), 32'h00A0);

      // 5b: FWFT
      c_wr = 1; c_din = 16'hBEEF;
      step();
      c_wr = 0;
      chk("fw_dout", 32'(c_dout), 32'hBEEF);
      chk("fw_dv", 32'(c_dv), 1);
      step();
      chk("fw_hold", 32'(c_dout), 32'hBEEF);
      chk("fw_cnt", 32'(c_cnt), 1);
      c_wr = 1; c_din = 16'h1234;
      step();
      c_wr = 0;
      chk("fw_head", 32'(c_dout), 32'hBEEF);
      c_rd = 1;
      step();
      chk("fw_next", 32'(c_dout), 32'h1234);
      chk("fw_dv2", 32'(c_dv), 1);
      step();
      c_rd = 0;
      chk("fw_empty_dv", 32'(c_dv), 0);
      chk("fw_cnt0", 32'(c_cnt), 0);

      // 6b: async reset mid-burst
      a_wr = 1;
      for (int i = 0; i < 3; i++) begin
         a_din = 16'(16'h0500 + i);
         step();
      end
      chk("rb_pre_cnt", 32'(a_cnt), 3);
      rst_n = 1'b0;
      #1;
      chk("rb_cnt", 32'(a_cnt), 0);
      chk("rb_empty", 32'(a_empty), 1);
      chk("rb_dout", 32'(a_dout), 0);
      chk("rb_ack", 32'(a_ack), 0);
      chk("rb_dv", 32'(a_dv), 0);
      chk("rb_b_full", 32'(b_full), 0);
      a_wr = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
